parallel_copy_sequencer: RTL and testbench

//  Back end of phi elimination. Takes one batch of parallel register copies (dst <- src) for a block edge.
//  All copies in a batch must appear to happen at once. Emits an equivalent sequential move list,

---
 rtl/parallel_copy_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_parallel_copy_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_copy_sequencer.sv
// parallel_copy_sequencer: turns one batch of parallel register copies into an
// equivalent sequential move list, breaking copy cycles through TMP_REG.
// Optional feature macro: PCS_STATS_EN (move / cycle-break counters).
module parallel_copy_sequencer #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MAX_COPIES = 8,
  parameter int unsigned TMP_REG    = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_dst,
  input  logic [REG_W-1:0] in_src,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_dst,
  output logic [REG_W-1:0] out_src,
  output logic             out_last,
  output logic             done,
  output logic             err,
  output logic [15:0]      stat_moves,
  output logic [15:0]      stat_brks
);

  localparam int unsigned CNT_W = $clog2(MAX_COPIES + 1);
  localparam int unsigned IDX_W = (MAX_COPIES > 1) ? $clog2(MAX_COPIES) : 1;
  localparam logic [REG_W-1:0] TMP = REG_W'(TMP_REG);

  typedef enum logic [1:0] {S_LOAD, S_SCHED, S_EMIT} state_e;

  state_e                  state_q, state_d;
  logic [MAX_COPIES-1:0]   vld_q, vld_d;
  logic [REG_W-1:0]        dst_q [MAX_COPIES];
  logic [REG_W-1:0]        dst_d [MAX_COPIES];
  logic [REG_W-1:0]        src_q [MAX_COPIES];
  logic [REG_W-1:0]        src_d [MAX_COPIES];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bad_q, bad_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [REG_W-1:0]        out_dst_q, out_dst_d;
  logic [REG_W-1:0]        out_src_q, out_src_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [MAX_COPIES-1:0]   rdy;
  logic                    any_rdy;
  logic [IDX_W-1:0]        rdy_idx;
  logic [IDX_W-1:0]        vld_idx;
  logic [CNT_W-1:0]        npend;
  logic                    new_bad;

  // A pending slot may be written once no other pending slot still reads its dst.
  always_comb begin
    rdy = '0;
    for (int unsigned i = 0; i < MAX_COPIES; i++) begin
      rdy[i] = vld_q[i];
      for (int unsigned j = 0; j < MAX_COPIES; j++) begin
        if (j != i && vld_q[j] && src_q[j] == dst_q[i]) rdy[i] = 1'b0;
      end
    end
  end

  // Lowest-index ready slot, lowest-index pending slot, and pending count.
  always_comb begin
    any_rdy = 1'b0;
    rdy_idx = '0;
    vld_idx = '0;
    npend   = '0;
    for (int i = int'(MAX_COPIES) - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        any_rdy = 1'b1;
        rdy_idx = IDX_W'(i);
      end
      if (vld_q[i]) vld_idx = IDX_W'(i);
    end
    for (int unsigned i = 0; i < MAX_COPIES; i++) npend = npend + CNT_W'(vld_q[i]);
  end

  // Next-state, table update and registered-output selection.
  always_comb begin
    state_d     = state_q;
    vld_d       = vld_q;
    dst_d       = dst_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    out_valid_d = out_valid_q;
    out_dst_d   = out_dst_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    new_bad     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          if (in_dst != in_src) begin
            if (in_dst == TMP || in_src == TMP || cnt_q == CNT_W'(MAX_COPIES)) new_bad = 1'b1;
            for (int unsigned i = 0; i < MAX_COPIES; i++) begin
              if (vld_q[i] && dst_q[i] == in_dst) new_bad = 1'b1;
            end
            if (!new_bad) begin
              for (int unsigned i = 0; i < MAX_COPIES; i++) begin
                if (CNT_W'(i) == cnt_q) begin
                  vld_d[i] = 1'b1;
                  dst_d[i] = in_dst;
                  src_d[i] = in_src;
                end
              end
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          bad_d = bad_q | new_bad;
          if (in_last) begin
            if (bad_d || cnt_d == '0) begin
              done_d = 1'b1;
              err_d  = bad_d;
              vld_d  = '0;
              cnt_d  = '0;
              bad_d  = 1'b0;
            end else begin
              state_d = S_SCHED;
            end
          end
        end
      end
      S_SCHED: begin
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
        if (any_rdy) begin
          out_dst_d      = dst_q[rdy_idx];
          out_src_d      = src_q[rdy_idx];
          out_last_d     = (npend == CNT_W'(1));
          vld_d[rdy_idx] = 1'b0;
        end else begin
          // Cycle: park the victim's old value in TMP and redirect its readers.
          out_dst_d  = TMP;
          out_src_d  = dst_q[vld_idx];
          out_last_d = 1'b0;
          for (int unsigned i = 0; i < MAX_COPIES; i++) begin
            if (vld_q[i] && src_q[i] == dst_q[vld_idx]) src_d[i] = TMP;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            done_d     = 1'b1;
            out_last_d = 1'b0;
            vld_d      = '0;
            cnt_d      = '0;
            bad_d      = 1'b0;
            state_d    = S_LOAD;
          end else begin
            state_d = S_SCHED;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign in_ready_d = (state_d == S_LOAD);

  // State, copy table and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      vld_q   <= '0;
      for (int unsigned i = 0; i < MAX_COPIES; i++) begin
        dst_q[i] <= '0;
        src_q[i] <= '0;
      end
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_dst_q   <= out_dst_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dst   = out_dst_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef PCS_STATS_EN
  logic [15:0] moves_q;
  logic [15:0] brks_q;

  // Saturating counters of emitted moves and of TMP_REG (cycle-break) moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moves_q <= '0;
      brks_q  <= '0;
    end else if (out_valid_q && out_ready) begin
      if (moves_q != 16'hFFFF) moves_q <= moves_q + 16'd1;
      if (out_dst_q == TMP && brks_q != 16'hFFFF) brks_q <= brks_q + 16'd1;
    end
  end

  assign stat_moves = moves_q;
  assign stat_brks  = brks_q;
`else
  assign stat_moves = 16'd0;
  assign stat_brks  = 16'd0;
`endif

endmodule

// File: tb/tb_parallel_copy_sequencer.sv
// Self-checking bench for parallel_copy_sequencer: directed vector table,
// hand-written backpressure / reset sequences and randomized batches checked
// against a register-file semantic model.
module tb_parallel_copy_sequencer;

  localparam int unsigned REG_W = 5;
  localparam int TMP = 31;
`ifdef PCS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [REG_W-1:0] in_dst, in_src;
  logic             out_valid, out_ready, out_last;
  logic [REG_W-1:0] out_dst, out_src;
  logic             done, err;
  logic [15:0]      stat_moves, stat_brks;

  always #5 clk = ~clk;

  parallel_copy_sequencer #(.REG_W(REG_W), .MAX_COPIES(8), .TMP_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst), .in_src(in_src), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst), .out_src(out_src),
    .out_last(out_last), .done(done), .err(err),
    .stat_moves(stat_moves), .stat_brks(stat_brks)
  );

  typedef struct {
    int               n;
    logic [9:0][4:0]  d;
    logic [9:0][4:0]  s;
    bit               e;
    int               nm;
    logic [3:0][4:0]  md;
    logic [3:0][4:0]  ms;
  } vec_t;

  vec_t tbl[8];
  int   n_checks = 0;
  int   n_pass   = 0;

  // current batch and its observed results
  int   cd[16];
  int   cs[16];
  int   cn;
  int   md[$];
  int   ms[$];
  bit   ml[$];
  bit   got_done, got_err, stable_ok, feed_to;
  int   first_valid_it, done_it, last_hs_it;
  int   exp_sm, exp_sb;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Number of cycles in the copy graph (self copies ignored).
  function automatic int count_cycles();
    int  pred[32];
    bit  isd[32];
    int  mark[32];
    int  b = 0;
    int  x;
    for (int k = 0; k < 32; k++) begin pred[k] = 0; isd[k] = 0; mark[k] = -1; end
    for (int i = 0; i < cn; i++)
      if (cd[i] != cs[i]) begin isd[cd[i]] = 1; pred[cd[i]] = cs[i]; end
    for (int i = 0; i < cn; i++) begin
      if (cd[i] == cs[i]) continue;
      x = cd[i];
      while (isd[x] && mark[x] == -1) begin mark[x] = i; x = pred[x]; end
      if (isd[x] && mark[x] == i) b++;
    end
    return b;
  endfunction

  function automatic int count_nonself();
    int n = 0;
    for (int i = 0; i < cn; i++) if (cd[i] != cs[i]) n++;
    return n;
  endfunction

  // Sequential replay of observed moves must equal the parallel copy.
  function automatic bit regs_ok();
    int r0[32];
    int r[32];
    int ex[32];
    for (int k = 0; k < 32; k++) begin r0[k] = k * 13 + 7; r[k] = r0[k]; ex[k] = r0[k]; end
    for (int i = 0; i < cn; i++) ex[cd[i]] = r0[cs[i]];
    for (int i = 0; i < md.size(); i++) r[md[i]] = r[ms[i]];
    for (int k = 0; k < 31; k++) if (r[k] != ex[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic feed();
    int w;
    feed_to = 0;
    for (int k = 0; k < cn; k++) begin
      in_valid = 1'b1;
      in_dst   = REG_W'(cd[k]);
      in_src   = REG_W'(cs[k]);
      in_last  = (k == cn - 1);
      w = 0;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin feed_to = 1; break; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_batch(input int hold, input int bp_pct);
    bit prev_v = 0;
    int pd = 0, ps = 0, vcnt = 0;
    bit pl = 0;
    md.delete(); ms.delete(); ml.delete();
    got_done = 0; got_err = 0; stable_ok = 1;
    first_valid_it = -1; done_it = -1; last_hs_it = -1;
    feed();
    check("feed_accepted", feed_to, 0);
    for (int it = 0; it < 400 && !got_done; it++) begin
      if (done) begin
        got_done = 1; got_err = err; done_it = it;
      end else begin
        if (out_valid) begin
          if (first_valid_it < 0) first_valid_it = it;
          if (prev_v && (int'(out_dst) != pd || int'(out_src) != ps || out_last != pl)) stable_ok = 0;
          out_ready = (vcnt >= hold) && (int'($urandom_range(99)) >= bp_pct);
          if (out_ready) begin
            md.push_back(int'(out_dst)); ms.push_back(int'(out_src)); ml.push_back(out_last);
            last_hs_it = it; prev_v = 0; vcnt = 0;
          end else begin
            prev_v = 1; pd = int'(out_dst); ps = int'(out_src); pl = out_last; vcnt++;
          end
        end else begin
          out_ready = 1'($urandom_range(1));
          prev_v = 0;
        end
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic check_batch(input string nm_s, input bit exp_err, input int exp_nm, input int exp_b);
    int nlast = 0;
    check({nm_s, "_done_seen"}, got_done, 1);
    check({nm_s, "_err"}, got_err, exp_err);
    check({nm_s, "_nmoves"}, md.size(), exp_nm);
    if (exp_nm > 0) begin
      check({nm_s, "_first_valid_lat"}, first_valid_it, 1);
      check({nm_s, "_done_lat"}, done_it, last_hs_it + 1);
      foreach (ml[i]) if (ml[i]) nlast++;
      check({nm_s, "_last_count"}, nlast, 1);
      check({nm_s, "_last_on_final"}, (md.size() > 0) ? ml[md.size()-1] : 0, 1);
      check({nm_s, "_stable"}, stable_ok, 1);
      check({nm_s, "_semantics"}, regs_ok(), 1);
    end else begin
      check({nm_s, "_done_lat"}, done_it, 0);
    end
    if (!exp_err) begin exp_sm += exp_nm; exp_sb += exp_b; end
    @(posedge clk); #1;
    check({nm_s, "_done_pulse"}, done, 0);
    check({nm_s, "_stat_moves"}, stat_moves, STATS ? exp_sm : 0);
    check({nm_s, "_stat_brks"}, stat_brks, STATS ? exp_sb : 0);
  endtask

  task automatic load_vec(input int v);
    cn = tbl[v].n;
    for (int i = 0; i < cn; i++) begin cd[i] = int'(tbl[v].d[i]); cs[i] = int'(tbl[v].s[i]); end
  endtask

  task automatic check_exact(input string nm_s, input int v);
    for (int k = 0; k < tbl[v].nm && k < md.size(); k++) begin
      check($sformatf("%s_mv%0d_dst", nm_s, k), md[k], int'(tbl[v].md[k]));
      check($sformatf("%s_mv%0d_src", nm_s, k), ms[k], int'(tbl[v].ms[k]));
    end
  endtask

  initial begin
    int perm[31];
    int tmp, j, w;
    for (int v = 0; v < 8; v++) begin
      tbl[v].n = 0; tbl[v].d = '0; tbl[v].s = '0; tbl[v].e = 0;
      tbl[v].nm = 0; tbl[v].md = '0; tbl[v].ms = '0;
    end
    // chain
    tbl[0].n = 2; tbl[0].d[0] = 1; tbl[0].s[0] = 2; tbl[0].d[1] = 2; tbl[0].s[1] = 3;
    tbl[0].nm = 2; tbl[0].md[0] = 1; tbl[0].ms[0] = 2; tbl[0].md[1] = 2; tbl[0].ms[1] = 3;
    // swap
    tbl[1].n = 2; tbl[1].d[0] = 1; tbl[1].s[0] = 2; tbl[1].d[1] = 2; tbl[1].s[1] = 1;
    tbl[1].nm = 3; tbl[1].md[0] = 31; tbl[1].ms[0] = 1; tbl[1].md[1] = 1; tbl[1].ms[1] = 2;
    tbl[1].md[2] = 2; tbl[1].ms[2] = 31;
    // self only
    tbl[2].n = 1; tbl[2].d[0] = 5; tbl[2].s[0] = 5;
    // duplicate dst
    tbl[3].n = 2; tbl[3].d[0] = 3; tbl[3].s[0] = 1; tbl[3].d[1] = 3; tbl[3].s[1] = 2; tbl[3].e = 1;
    // overflow: 9 distinct copies
    tbl[4].n = 9; tbl[4].e = 1;
    for (int i = 0; i < 9; i++) begin tbl[4].d[i] = 5'(i + 1); tbl[4].s[i] = 5'(i + 10); end
    // scratch register in source
    tbl[5].n = 1; tbl[5].d[0] = 4; tbl[5].s[0] = 31; tbl[5].e = 1;
    // 3-cycle rotation
    tbl[6].n = 3; tbl[6].d[0] = 1; tbl[6].s[0] = 2; tbl[6].d[1] = 2; tbl[6].s[1] = 3;
    tbl[6].d[2] = 3; tbl[6].s[2] = 1; tbl[6].nm = 4;
    tbl[6].md[0] = 31; tbl[6].ms[0] = 1; tbl[6].md[1] = 1; tbl[6].ms[1] = 2;
    tbl[6].md[2] = 2;  tbl[6].ms[2] = 3; tbl[6].md[3] = 3; tbl[6].ms[3] = 31;
    // self copy mixed with a chain
    tbl[7].n = 3; tbl[7].d[0] = 7; tbl[7].s[0] = 7; tbl[7].d[1] = 6; tbl[7].s[1] = 5;
    tbl[7].d[2] = 5; tbl[7].s[2] = 4; tbl[7].nm = 2;
    tbl[7].md[0] = 6; tbl[7].ms[0] = 5; tbl[7].md[1] = 5; tbl[7].ms[1] = 4;

    exp_sm = 0; exp_sb = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_dst = '0; in_src = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_dst", out_dst, 0);
    check("rst_out_src", out_src, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_stat_moves", stat_moves, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed table
    for (int v = 0; v < 8; v++) begin
      load_vec(v);
      run_batch(0, 30);
      check_batch($sformatf("vec%0d", v), tbl[v].e, tbl[v].nm, count_cycles());
      check_exact($sformatf("vec%0d", v), v);
    end

    // backpressure: out_ready held low 5 cycles on every move
    load_vec(1);
    run_batch(5, 0);
    check_batch("bp_swap", 1'b0, 3, 1);
    check_exact("bp_swap", 1);

    // reset during the 2nd of 3 moves
    cn = 3; cd[0] = 1; cs[0] = 2; cd[1] = 2; cs[1] = 3; cd[2] = 3; cs[2] = 4;
    feed();
    out_ready = 1'b1;
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    check("rstmid_first_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    check("rstmid_second_valid", out_valid, 1);
    check("rstmid_second_dst", out_dst, 2);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_dst", out_dst, 0);
    check("rstmid_out_src", out_src, 0);
    check("rstmid_out_last", out_last, 0);
    check("rstmid_done", done, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_stat_moves", stat_moves, 0);
    exp_sm = 0; exp_sb = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_no_done", done, 0);
    load_vec(0);
    run_batch(0, 0);
    check_batch("post_rst_chain", 1'b0, 2, 0);
    check_exact("post_rst_chain", 0);

    // randomized batches against the semantic model
    for (int b = 0; b < 40; b++) begin
      for (int k = 0; k < 31; k++) perm[k] = k;
      for (int k = 30; k > 0; k--) begin
        j = int'($urandom_range(k)); tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
      cn = int'($urandom_range(1, 8));
      for (int k = 0; k < cn; k++) begin
        cd[k] = perm[k];
        if ($urandom_range(99) < 15) cs[k] = cd[k];
        else if ($urandom_range(1) == 1) cs[k] = perm[$urandom_range(cn - 1)];
        else cs[k] = int'($urandom_range(30));
      end
      run_batch(int'($urandom_range(2)), 40);
      check_batch($sformatf("rnd%0d", b), 1'b0, count_nonself() + count_cycles(), count_cycles());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
